// File: rtl/spi_packet_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_packet_master_pkg
// Description : Shared constants, state encoding and packet helper for the
//               SPI packet master.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_packet_master_pkg;

    localparam logic [7:0]  c_start_byte_default = 8'hF0;
    localparam int unsigned c_pkt_bits           = 24;
    localparam int unsigned c_bit_cnt_w          = 5;
    localparam int unsigned c_div_cnt_w          = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    function automatic logic [c_pkt_bits-1:0] build_packet(
        input logic [7:0] start_byte,
        input logic [7:0] addr,
        input logic [7:0] data
    );
        return {start_byte, addr, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_div
// Description : Half-period counter producing a tick every CLK_DIV cycles
//               while enabled; held at zero when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div
    import spi_packet_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    output logic                   o_tick,
    output logic [c_div_cnt_w-1:0] o_cnt
);

    localparam logic [c_div_cnt_w-1:0] c_last_cnt = c_div_cnt_w'(CLK_DIV - 1);

    logic [c_div_cnt_w-1:0] cnt_q;
    logic [c_div_cnt_w-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!i_en) begin
            cnt_d = '0;
        end else if (cnt_q == c_last_cnt) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + c_div_cnt_w'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = i_en && (cnt_q == c_last_cnt);
    assign o_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/spi_packet_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_packet_master
// Description : Mode-0 SPI master sending a 3-byte packet (start, addr, data)
//               MSB first while capturing MISO into o_rx_data.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_packet_master
    import spi_packet_master_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [7:0]  START_BYTE = c_start_byte_default
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_send,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_data,
    input  logic       i_MISO,
    output logic       o_SCLK,
    output logic       o_MOSI,
    output logic       o_SSEL,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [7:0] o_rx_data
);

    localparam logic [c_bit_cnt_w-1:0] c_last_bit = c_bit_cnt_w'(c_pkt_bits - 1);
    // GAP is one cycle short so the IDLE/done cycle completes the deselect time.
    localparam logic [c_div_cnt_w-1:0] c_gap_last = c_div_cnt_w'(CLK_DIV - 2);

    state_t                  state_q,   state_d;
    logic [c_pkt_bits-1:0]   tx_q,      tx_d;
    logic [6:0]              rx_sh_q,   rx_sh_d;
    logic [7:0]              rx_data_q, rx_data_d;
    logic [c_bit_cnt_w-1:0]  bit_cnt_q, bit_cnt_d;
    logic                    sclk_q,    sclk_d;
    logic                    ssel_q,    ssel_d;
    logic                    busy_q,    busy_d;
    logic                    done_q,    done_d;
    logic                    err_q,     err_d;

    logic                    w_div_en;
    logic                    w_tick;
    logic [c_div_cnt_w-1:0]  w_cnt;
    logic                    w_accept;

    assign w_div_en = (state_q != ST_IDLE);
    assign w_accept = i_send && (state_q == ST_IDLE) && !busy_q;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_div_en),
        .o_tick (w_tick),
        .o_cnt  (w_cnt)
    );

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        ssel_d    = ssel_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (i_addr == START_BYTE) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = ST_SETUP;
                        tx_d      = build_packet(START_BYTE, i_addr, i_data);
                        bit_cnt_d = '0;
                        sclk_d    = 1'b0;
                        ssel_d    = 1'b0;
                        busy_d    = 1'b1;
                    end
                end
            end

            ST_SETUP: begin
                if (w_tick) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[5:0], i_MISO};
                end
            end

            ST_SHIFT: begin
                if (w_tick) begin
                    if (sclk_q) begin
                        // Falling edge: present the next bit; zeros fill in behind.
                        sclk_d = 1'b0;
                        tx_d   = {tx_q[c_pkt_bits-2:0], 1'b0};
                    end else if (bit_cnt_q == c_last_bit) begin
                        state_d   = ST_HOLD;
                        bit_cnt_d = '0;
                    end else begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + c_bit_cnt_w'(1);
                        rx_sh_d   = {rx_sh_q[5:0], i_MISO};
                        if (bit_cnt_q[2:0] == 3'd6) begin
                            rx_data_d = {rx_sh_q, i_MISO};
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (w_tick) begin
                    state_d = ST_GAP;
                    ssel_d  = 1'b1;
                end
            end

            ST_GAP: begin
                if (w_cnt == c_gap_last) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ssel_d  = 1'b1;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
                tx_d    = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= 8'h00;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            ssel_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            ssel_q    <= ssel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // tx_q is all-zero once the 24th bit has shifted out, so MOSI idles low.
    assign o_MOSI    = tx_q[c_pkt_bits-1];
    assign o_SCLK    = sclk_q;
    assign o_SSEL    = ssel_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_rx_data = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_packet_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_packet_master
// Description : Randomized scoreboard bench with a behavioural SPI slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_packet_master;

    localparam int CLK_DIV = 4;
    localparam int PKT_CYC = 51 * CLK_DIV;

    logic       clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_send = 1'b0;
    logic [7:0] i_addr = 8'h00;
    logic [7:0] i_data = 8'h00;
    logic       i_MISO;
    logic       o_SCLK, o_MOSI, o_SSEL, o_busy, o_done, o_err;
    logic [7:0] o_rx_data;

    spi_packet_master #(
        .CLK_DIV    (CLK_DIV),
        .START_BYTE (8'hF0)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_send    (i_send),
        .i_addr    (i_addr),
        .i_data    (i_data),
        .i_MISO    (i_MISO),
        .o_SCLK    (o_SCLK),
        .o_MOSI    (o_MOSI),
        .o_SSEL    (o_SSEL),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err),
        .o_rx_data (o_rx_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          start;
        logic [23:0] pkt;
    } pkt_exp_t;

    pkt_exp_t    pkt_q[$];
    int          done_q[$];
    int          err_q[$];
    logic [23:0] miso_q[$];
    logic [7:0]  rx_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc  = 0;
    int next_ok = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Reference: packet is start byte, address, data concatenated numerically.
    function automatic logic [23:0] model_pkt(input int a, input int d);
        return 24'((240 * 65536) + (a * 256) + d);
    endfunction

    // ---------------- monitor + behavioural slave ----------------
    initial begin
        logic        prev_ssel, prev_sclk, prev_mosi, in_pkt;
        logic [23:0] cur_pat, got;
        int          nbits, low_start, viol;
        pkt_exp_t    e;
        i_MISO    = 1'b0;
        prev_ssel = 1'b1;
        prev_sclk = 1'b0;
        prev_mosi = 1'b0;
        in_pkt    = 1'b0;
        cur_pat   = '0;
        got       = '0;
        nbits     = 0;
        low_start = 0;
        viol      = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (i_rst) begin
                in_pkt = 1'b0;
                i_MISO = 1'b0;
            end else begin
                if (o_SSEL && o_MOSI) viol++;
                if (o_SSEL && o_SCLK) viol++;
                if (prev_ssel && !o_SSEL) begin
                    in_pkt    = 1'b1;
                    low_start = ncyc;
                    nbits     = 0;
                    got       = '0;
                    cur_pat   = (miso_q.size() > 0) ? miso_q.pop_front() : 24'h0;
                    i_MISO    = cur_pat[23];
                end else if (in_pkt && !o_SSEL && (o_MOSI != prev_mosi) && !(prev_sclk && !o_SCLK)) begin
                    viol++;
                end
                if (in_pkt && !prev_sclk && o_SCLK) begin
                    got = {got[22:0], o_MOSI};
                    nbits++;
                    if (nbits < 24) i_MISO = cur_pat[5'(23 - nbits)];
                end
                if (in_pkt && prev_sclk && !o_SCLK && nbits > 0 && (nbits % 8) == 0) begin
                    check("rx_pending", 32'(rx_q.size() > 0), 32'd1);
                    if (rx_q.size() > 0) check("rx_data", 32'(o_rx_data), 32'(rx_q.pop_front()));
                end
                if (!prev_ssel && o_SSEL && in_pkt) begin
                    in_pkt = 1'b0;
                    check("pkt_pending", 32'(pkt_q.size() > 0), 32'd1);
                    if (pkt_q.size() > 0) begin
                        e = pkt_q.pop_front();
                        check("mosi_packet", 32'(got), 32'(e.pkt));
                        check("ssel_start", 32'(low_start), 32'(e.start));
                    end
                    check("sclk_rises", 32'(nbits), 32'd24);
                    check("ssel_low_len", 32'(ncyc - low_start), 32'(50 * CLK_DIV));
                    check("line_rules", 32'(viol), 32'd0);
                    viol = 0;
                end
                if (o_done) begin
                    check("done_pending", 32'(done_q.size() > 0), 32'd1);
                    if (done_q.size() > 0) check("done_cycle", 32'(ncyc), 32'(done_q.pop_front()));
                    check("done_busy", 32'(o_busy), 32'd0);
                end
                if (o_err) begin
                    check("err_pending", 32'(err_q.size() > 0), 32'd1);
                    if (err_q.size() > 0) check("err_cycle", 32'(ncyc), 32'(err_q.pop_front()));
                    check("err_ssel", 32'(o_SSEL), 32'd1);
                end
            end
            prev_ssel = o_SSEL;
            prev_sclk = o_SCLK;
            prev_mosi = o_MOSI;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_until(input int target);
        while (ncyc < target) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic expect_pkt(input int acc, input logic [7:0] a, input logic [7:0] d,
                              input logic [23:0] pat);
        int p;
        p = int'(pat);
        pkt_q.push_back('{start: acc + 1, pkt: model_pkt(int'(a), int'(d))});
        done_q.push_back(acc + PKT_CYC);
        miso_q.push_back(pat);
        rx_q.push_back(8'((p / 65536) % 256));
        rx_q.push_back(8'((p / 256) % 256));
        rx_q.push_back(8'(p % 256));
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] d, input logic [23:0] pat);
        int acc;
        i_send = 1'b1;
        i_addr = a;
        i_data = d;
        acc    = ncyc;
        if (a == 8'hF0) begin
            err_q.push_back(acc + 1);
            next_ok = acc + 1;
        end else begin
            expect_pkt(acc, a, d, pat);
            next_ok = acc + PKT_CYC;
        end
        @(negedge clk);
        #1;
        i_send = 1'b0;
    endtask

    initial begin
        int acc;
        int t;
        logic [7:0]  a, d;
        logic [23:0] pat;

        #1 i_rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ssel",  32'(o_SSEL),    32'd1);
        check("rst_sclk",  32'(o_SCLK),    32'd0);
        check("rst_mosi",  32'(o_MOSI),    32'd0);
        check("rst_busy",  32'(o_busy),    32'd0);
        check("rst_done",  32'(o_done),    32'd0);
        check("rst_err",   32'(o_err),     32'd0);
        check("rst_rx",    32'(o_rx_data), 32'd0);
        i_rst = 1'b0;
        @(negedge clk);
        #1;

        // Directed packet, MISO carries A5 in sample bits 8..15.
        send_pkt(8'h12, 8'h34, {8'($urandom), 8'hA5, 8'($urandom)});
        wait_until(next_ok + 2);

        // Reserved address is rejected.
        send_pkt(8'hF0, 8'h55, 24'h0);
        wait_until(next_ok + 10);

        // i_send held: second accept lands on the done cycle.
        i_send = 1'b1;
        i_addr = 8'h3C;
        i_data = 8'hC3;
        acc    = ncyc;
        pat    = 24'($urandom);
        expect_pkt(acc, 8'h3C, 8'hC3, pat);
        pat    = 24'($urandom);
        expect_pkt(acc + PKT_CYC, 8'h3C, 8'hC3, pat);
        wait_until(acc + PKT_CYC + 1);
        i_send = 1'b0;
        wait_until(acc + 2 * PKT_CYC + 2);

        // Reset in the middle of a packet aborts it at once.
        i_send = 1'b1;
        i_addr = 8'h77;
        i_data = 8'h88;
        acc    = ncyc;
        miso_q.push_back(24'($urandom));
        @(negedge clk);
        #1;
        i_send = 1'b0;
        wait_until(acc + 60);
        i_rst = 1'b1;
        #1;
        check("abort_ssel", 32'(o_SSEL), 32'd1);
        check("abort_sclk", 32'(o_SCLK), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_mosi", 32'(o_MOSI), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        i_rst = 1'b0;
        @(negedge clk);
        #1;
        send_pkt(8'h5A, 8'h69, 24'($urandom));

        // Randomized traffic, occasionally with the reserved address.
        for (int i = 0; i < 8; i++) begin
            a   = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom);
            d   = 8'($urandom);
            pat = 24'($urandom);
            wait_until(next_ok + int'($urandom_range(0, 3)));
            send_pkt(a, d, pat);
        end

        t = 0;
        while ((pkt_q.size() + done_q.size() + err_q.size() + rx_q.size()) != 0 && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("drain_pkt",  32'(pkt_q.size()),  32'd0);
        check("drain_done", 32'(done_q.size()), 32'd0);
        check("drain_err",  32'(err_q.size()),  32'd0);
        check("drain_rx",   32'(rx_q.size()),   32'd0);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
